// File: rtl/ebus_xfer_ctl.sv
//------------------------------------------------------------------------------
// Module      : ebus_xfer_ctl
// Description : EBOX-side EBUS single-word transfer sequencer (CS/FUNC setup,
//               DEMAND/XFER handshake, timeout). Optional macro EBUS_PARITY_EN
//               adds odd data parity on the bus and a sticky parity error.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ebus_xfer_ctl #(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int DATA_W      = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir_wr,
    input  logic [0:6]        cs_in,
    input  logic [0:2]        func_in,
    input  logic [0:DATA_W-1] wdata,
    input  logic              ebus_xfer,
    input  logic [0:DATA_W-1] ebus_din,
`ifdef EBUS_PARITY_EN
    input  logic              ebus_dpar_in,
    output logic              ebus_dpar_out,
    output logic              par_err,
`endif
    output logic [0:6]        ebus_cs,
    output logic [0:2]        ebus_func,
    output logic              ebus_demand,
    output logic              ebus_drive,
    output logic [0:DATA_W-1] ebus_dout,
    output logic [0:DATA_W-1] rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_DEMAND  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

    state_t              state_q;
    logic [3:0]          scnt_q;
    logic [15:0]         tcnt_q;
    logic                xs_meta_q;
    logic                xs_q;
    logic                xs_prev_q;
    logic                dir_q;
    logic [0:6]          cs_q;
    logic [0:2]          func_q;
    logic [0:DATA_W-1]   dout_q;
    logic [0:DATA_W-1]   rdata_q;
    logic                demand_q;
    logic                drive_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
`ifdef EBUS_PARITY_EN
    logic                dpar_q;
    logic                par_err_q;
`endif

    logic                xfer_rise_d;
    logic                finish_d;

    // A rise is only seen once XFER was observed low first, so an XFER left
    // high from before DEMAND never counts as an acknowledge.
    assign xfer_rise_d = xs_q & ~xs_prev_q;
    assign finish_d    = ((state_q == ST_DEMAND) && !xfer_rise_d && (tcnt_q == TO_LAST)) ||
                         ((state_q == ST_RELEASE) && !xs_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            tcnt_q    <= '0;
            xs_meta_q <= 1'b0;
            xs_q      <= 1'b0;
            xs_prev_q <= 1'b0;
            dir_q     <= 1'b0;
            cs_q      <= '0;
            func_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            demand_q  <= 1'b0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef EBUS_PARITY_EN
            dpar_q    <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            xs_meta_q <= ebus_xfer;
            xs_q      <= xs_meta_q;
            xs_prev_q <= xs_q;
            done_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dir_q     <= dir_wr;
                        cs_q      <= cs_in;
                        func_q    <= func_in;
                        dout_q    <= wdata;
                        drive_q   <= dir_wr;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        scnt_q    <= SETUP_LAST;
                        state_q   <= ST_SETUP;
`ifdef EBUS_PARITY_EN
                        dpar_q    <= ~^wdata;
                        par_err_q <= 1'b0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (scnt_q == 4'd0) begin
                        demand_q <= 1'b1;
                        tcnt_q   <= '0;
                        state_q  <= ST_DEMAND;
                    end else begin
                        scnt_q <= scnt_q - 4'd1;
                    end
                end
                ST_DEMAND: begin
                    if (xfer_rise_d) begin
                        if (!dir_q) begin
                            rdata_q <= ebus_din;
`ifdef EBUS_PARITY_EN
                            if ((^ebus_din ^ ebus_dpar_in) != 1'b1) begin
                                par_err_q <= 1'b1;
                            end
`endif
                        end
                        demand_q <= 1'b0;
                        state_q  <= ST_RELEASE;
                    end else if (tcnt_q == TO_LAST) begin
                        demand_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!xs_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Bus fields are released as the DONE pulse begins.
            if (finish_d) begin
                done_q  <= 1'b1;
                cs_q    <= '0;
                func_q  <= '0;
                dout_q  <= '0;
                drive_q <= 1'b0;
`ifdef EBUS_PARITY_EN
                dpar_q  <= 1'b1;
`endif
            end
        end
    end

    assign ebus_cs     = cs_q;
    assign ebus_func   = func_q;
    assign ebus_demand = demand_q;
    assign ebus_drive  = drive_q;
    assign ebus_dout   = dout_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
`ifdef EBUS_PARITY_EN
    assign ebus_dpar_out = dpar_q;
    assign par_err       = par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ebus_xfer_ctl.sv
//------------------------------------------------------------------------------
// Module      : tb_ebus_xfer_ctl
// Description : Self-checking bench for ebus_xfer_ctl (scoreboard on done).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ebus_xfer_ctl;

    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dir_wr = 1'b0;
    logic [0:6]    cs_in = '0;
    logic [0:2]    func_in = '0;
    logic [0:DW-1] wdata = '0;
    logic          ebus_xfer = 1'b0;
    logic [0:DW-1] ebus_din = '0;
    logic [0:6]    ebus_cs;
    logic [0:2]    ebus_func;
    logic          ebus_demand;
    logic          ebus_drive;
    logic [0:DW-1] ebus_dout;
    logic [0:DW-1] rdata;
    logic          busy;
    logic          done;
    logic          timeout;
`ifdef EBUS_PARITY_EN
    logic          ebus_dpar_in = 1'b0;
    logic          ebus_dpar_out;
    logic          par_err;
`endif

    ebus_xfer_ctl #(
        .SETUP_CYC   (2),
        .TIMEOUT_CYC (16),
        .DATA_W      (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dir_wr      (dir_wr),
        .cs_in       (cs_in),
        .func_in     (func_in),
        .wdata       (wdata),
        .ebus_xfer   (ebus_xfer),
        .ebus_din    (ebus_din),
`ifdef EBUS_PARITY_EN
        .ebus_dpar_in  (ebus_dpar_in),
        .ebus_dpar_out (ebus_dpar_out),
        .par_err       (par_err),
`endif
        .ebus_cs     (ebus_cs),
        .ebus_func   (ebus_func),
        .ebus_demand (ebus_demand),
        .ebus_drive  (ebus_drive),
        .ebus_dout   (ebus_dout),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] rd;
        logic          to;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected completion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_one_pulse", {63'd0, done_prev}, 64'd0);
            chk("done_busy", {63'd0, busy}, 64'd1);
            if (sbq.size() == 0) begin
                chk("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_rdata", {28'd0, rdata}, {28'd0, e.rd});
                chk("sb_timeout", {63'd0, timeout}, {63'd0, e.to});
            end
        end
        done_prev = rst_n ? done : 1'b0;
    end

    // sel 0 = ebus_demand, 1 = done; returns on a negedge
    task automatic wait_lvl(input int sel, input logic lvl, input string name);
        for (int i = 0; i < 200; i++) begin
            if (((sel == 0) ? ebus_demand : done) == lvl) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_%s actual=timeout required=level_%0d", name, lvl);
    endtask

    task automatic issue(input logic wr, input logic [0:6] cs, input logic [0:2] fn,
                         input logic [0:DW-1] wd);
        start   = 1'b1;
        dir_wr  = wr;
        cs_in   = cs;
        func_in = fn;
        wdata   = wd;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic do_ack(input logic [0:DW-1] d);
        wait_lvl(0, 1'b1, "ack_demand_hi");
        ebus_din  = d;
        ebus_xfer = 1'b1;
        wait_lvl(0, 1'b0, "ack_demand_lo");
        @(negedge clk);
        ebus_xfer = 1'b0;
        wait_lvl(1, 1'b1, "ack_done");
        @(negedge clk);
    endtask

    localparam logic [0:DW-1] RD1 = 36'o123456701234;
    localparam logic [0:DW-1] WR1 = 36'o777777000001;
    int t0;
    int t1;
    int n;

    initial begin
        // Reset state
        #3;
        chk("rst_demand", {63'd0, ebus_demand}, 64'd0);
        chk("rst_drive", {63'd0, ebus_drive}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_rdata", {28'd0, rdata}, 64'd0);
        chk("rst_cs", {57'd0, ebus_cs}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read, device acks 3 clocks after DEMAND
        sbq.push_back('{rd: RD1, to: 1'b0});
        t0 = cyc;
        issue(1'b0, 7'o14, 3'b001, '0);
        wait_lvl(0, 1'b1, "rd_demand");
        chk("rd_demand_latency", 64'(cyc - t0), 64'd3);
        chk("rd_cs", {57'd0, ebus_cs}, 64'o14);
        chk("rd_func", {61'd0, ebus_func}, 64'd1);
        chk("rd_drive", {63'd0, ebus_drive}, 64'd0);
        repeat (3) @(negedge clk);
        ebus_din  = RD1;
        ebus_xfer = 1'b1;
        t1 = cyc;
        wait_lvl(0, 1'b0, "rd_demand_fall");
        chk("rd_capture_latency", 64'(cyc - t1), 64'd3);
        repeat (2) @(negedge clk);
        ebus_xfer = 1'b0;
        wait_lvl(1, 1'b1, "rd_done");
        @(negedge clk);
        chk("rd_busy_after", {63'd0, busy}, 64'd0);
        chk("rd_timeout_after", {63'd0, timeout}, 64'd0);
        chk("rd_rdata_after", {28'd0, rdata}, {28'd0, RD1});

        // Write
        sbq.push_back('{rd: RD1, to: 1'b0});
        issue(1'b1, 7'o3, 3'b101, WR1);
        chk("wr_drive_early", {63'd0, ebus_drive}, 64'd1);
        chk("wr_dout_early", {28'd0, ebus_dout}, {28'd0, WR1});
        wait_lvl(0, 1'b1, "wr_demand");
        ebus_xfer = 1'b1;
        wait_lvl(0, 1'b0, "wr_demand_fall");
        chk("wr_drive_release", {63'd0, ebus_drive}, 64'd1);
        chk("wr_dout_release", {28'd0, ebus_dout}, {28'd0, WR1});
        @(negedge clk);
        ebus_xfer = 1'b0;
        wait_lvl(1, 1'b1, "wr_done");
        @(negedge clk);
        chk("wr_drive_after", {63'd0, ebus_drive}, 64'd0);
        chk("wr_dout_after", {28'd0, ebus_dout}, 64'd0);
        chk("wr_cs_after", {57'd0, ebus_cs}, 64'd0);
        chk("wr_rdata_kept", {28'd0, rdata}, {28'd0, RD1});

        // Timeout: XFER never comes
        sbq.push_back('{rd: RD1, to: 1'b1});
        issue(1'b0, 7'o2, 3'b010, '0);
        wait_lvl(0, 1'b1, "to_demand");
        n = 0;
        while (ebus_demand && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("to_demand_len", 64'(n), 64'd16);
        chk("to_flag", {63'd0, timeout}, 64'd1);
        @(negedge clk);
        chk("to_sticky", {63'd0, timeout}, 64'd1);
        sbq.push_back('{rd: RD1, to: 1'b0});
        issue(1'b1, 7'o4, 3'b011, 36'o5);
        chk("to_cleared", {63'd0, timeout}, 64'd0);
        do_ack(36'o0);

        // Back-to-back with start held high
        sbq.push_back('{rd: 36'o111, to: 1'b0});
        start   = 1'b1;
        dir_wr  = 1'b0;
        cs_in   = 7'o21;
        func_in = 3'b010;
        @(negedge clk);
        cs_in   = 7'o55;
        func_in = 3'b110;
        wait_lvl(0, 1'b1, "b2b_demand");
        chk("b2b_cs_hold", {57'd0, ebus_cs}, 64'o21);
        chk("b2b_func_hold", {61'd0, ebus_func}, 64'd2);
        ebus_din  = 36'o111;
        ebus_xfer = 1'b1;
        wait_lvl(0, 1'b0, "b2b_demand_fall");
        @(negedge clk);
        ebus_xfer = 1'b0;
        sbq.push_back('{rd: 36'o222, to: 1'b0});
        wait_lvl(1, 1'b1, "b2b_done");
        @(negedge clk);
        chk("b2b_idle_gap", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("b2b_second_busy", {63'd0, busy}, 64'd1);
        chk("b2b_second_cs", {57'd0, ebus_cs}, 64'o55);
        chk("b2b_second_func", {61'd0, ebus_func}, 64'd6);
        start = 1'b0;
        do_ack(36'o222);

`ifdef EBUS_PARITY_EN
        sbq.push_back('{rd: 36'o1, to: 1'b0});
        ebus_dpar_in = 1'b1;
        issue(1'b0, 7'o1, 3'b000, '0);
        do_ack(36'o1);
        chk("par_err_set", {63'd0, par_err}, 64'd1);
        sbq.push_back('{rd: 36'o1, to: 1'b0});
        ebus_dpar_in = 1'b0;
        issue(1'b0, 7'o1, 3'b000, '0);
        do_ack(36'o1);
        chk("par_err_clear", {63'd0, par_err}, 64'd0);
`endif

        // Async reset mid-DEMAND on a write
        issue(1'b1, 7'o7, 3'b100, 36'o42);
        wait_lvl(0, 1'b1, "ar_demand");
        chk("ar_drive_before", {63'd0, ebus_drive}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_demand", {63'd0, ebus_demand}, 64'd0);
        chk("ar_drive", {63'd0, ebus_drive}, 64'd0);
        chk("ar_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        ebus_din  = 36'o7;
        ebus_xfer = 1'b1;
        repeat (6) @(negedge clk);
        chk("ar_rdata_unchanged", {28'd0, rdata}, 64'd0);
        chk("ar_idle_demand", {63'd0, ebus_demand}, 64'd0);
        chk("ar_idle_busy", {63'd0, busy}, 64'd0);
        ebus_xfer = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
